// File: rtl/phase_scheduler_if.sv
// Signal-head bus between the intersection controller and its sensors/lamps.
// The master drives the vehicle sensors. The slave is the scheduler, which drives the lamp, grant and phase outputs.
interface phase_scheduler_if;
  logic [3:0] req;
  logic [7:0] sig;
  logic [1:0] grant;
  logic [1:0] phase;

  modport master (output req, input sig, grant, phase);
  modport slave  (input req, output sig, grant, phase);
endinterface

// File: rtl/phase_scheduler.sv
// Four-approach round-robin intersection scheduler. Approach 0 is the home approach.
// Each grant runs green, then yellow, then all-red, all timed by one shared interval counter.
module phase_scheduler #(
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 10,
  parameter int unsigned Y2R_DELAY = 3,
  parameter int unsigned R2G_DELAY = 2
) (
  input  logic              clk,
  input  logic              clr,
  phase_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    ALLRED = 2'd2
  } state_e;

  localparam logic [1:0] LAMP_RED    = 2'd0;
  localparam logic [1:0] LAMP_YELLOW = 2'd1;
  localparam logic [1:0] LAMP_GREEN  = 2'd2;

  localparam logic [7:0] MIN_LAST = 8'(MIN_GREEN - 1);
  localparam logic [7:0] MAX_LAST = 8'(MAX_GREEN - 1);
  localparam logic [7:0] Y_LAST   = 8'(Y2R_DELAY - 1);
  localparam logic [7:0] R_LAST   = 8'(R2G_DELAY - 1);

  state_e     state_q, state_d;
  logic [1:0] cur_q, cur_d;
  logic [1:0] nxt_q, nxt_d;
  logic [3:0] pend_q, pend_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] sig_q, sig_d;
  logic [1:0] grant_q;
  logic [1:0] phase_q;

  logic [3:0] eff_pend;
  logic       wait_any;
  logic [1:0] winner;
  logic [1:0] idx;
  logic [1:0] lamp_d;
  logic       green_done;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d  = state_q;
    cur_d    = cur_q;
    nxt_d    = nxt_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q | bus.req;
    idx      = cur_q;
    winner   = cur_q;
    lamp_d   = LAMP_RED;

    // A non-home owner always sees home as pending, so right-of-way drifts back to 0.
    eff_pend = pend_q;
    if (cur_q != 2'd0) eff_pend[0] = 1'b1;
    wait_any = |(eff_pend & ~(4'b0001 << cur_q));

    // Scan from cur+3 down to cur+1, so the closest candidate after cur wins.
    for (int k = 3; k >= 1; k--) begin
      idx = cur_q + 2'(k);
      if (eff_pend[idx]) winner = idx;
    end

    green_done = (cnt_q >= MIN_LAST) && wait_any &&
                 (!bus.req[cur_q] || (cnt_q >= MAX_LAST));

    unique case (state_q)
      GREEN: begin
        pend_d[cur_q] = 1'b0;
        if (green_done) begin
          nxt_d   = winner;
          state_d = YELLOW;
          cnt_d   = 8'd0;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      YELLOW: begin
        if (cnt_q == Y_LAST) begin
          state_d = ALLRED;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ALLRED: begin
        if (cnt_q == R_LAST) begin
          state_d        = GREEN;
          cur_d          = nxt_q;
          cnt_d          = 8'd0;
          pend_d[nxt_q]  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = GREEN;
        cnt_d   = 8'd0;
      end
    endcase

    // Lamps are derived from the next state, so they are registered in step with state/cur.
    unique case (state_d)
      GREEN:   lamp_d = LAMP_GREEN;
      YELLOW:  lamp_d = LAMP_YELLOW;
      default: lamp_d = LAMP_RED;
    endcase
    sig_d = {6'b0, lamp_d} << {cur_d, 1'b0};
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= GREEN;
      cur_q   <= 2'd0;
      nxt_q   <= 2'd0;
      pend_q  <= 4'd0;
      cnt_q   <= 8'd0;
      sig_q   <= {6'b0, LAMP_GREEN};
      grant_q <= 2'd0;
      phase_q <= GREEN;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      grant_q <= cur_d;
      phase_q <= state_d;
    end
  end

  assign bus.sig   = sig_q;
  assign bus.grant = grant_q;
  assign bus.phase = phase_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed and random checks of phase_scheduler against an interval-based reference model.
module tb_phase_scheduler;
  localparam int MIN_G = 4;
  localparam int MAX_G = 10;
  localparam int Y2R   = 3;
  localparam int R2G   = 2;

  logic clk = 1'b0;
  logic clr = 1'b0;

  phase_scheduler_if bus();

  phase_scheduler #(
    .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .Y2R_DELAY(Y2R), .R2G_DELAY(R2G)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state. mode: 0 green, 1 yellow, 2 all-red.
  // m_len counts the cycles spent in the current interval, including this one.
  int       m_mode, m_cur, m_nxt, m_len;
  bit [3:0] m_pend;

  // Queue of grants taken at each new green, plus per-phase cycle tallies.
  int gq[$];
  int g_cyc, y_cyc, r_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] r, input logic c);
    bit [3:0] eff, np;
    bit       others;
    if (!c) begin
      m_mode = 0; m_cur = 0; m_nxt = 0; m_len = 1; m_pend = '0;
      return;
    end
    eff = m_pend;
    if (m_cur != 0) eff[0] = 1'b1;
    others = 1'b0;
    for (int j = 0; j < 4; j++) if (j != m_cur && eff[j]) others = 1'b1;
    np = m_pend | r;
    case (m_mode)
      0: begin
        np[m_cur] = 1'b0;
        if (m_len >= MIN_G && others && (!r[m_cur] || m_len >= MAX_G)) begin
          for (int k = 3; k >= 1; k--) if (eff[(m_cur + k) % 4]) m_nxt = (m_cur + k) % 4;
          m_mode = 1; m_len = 1;
        end else m_len++;
      end
      1: begin
        if (m_len == Y2R) begin m_mode = 2; m_len = 1; end
        else m_len++;
      end
      default: begin
        if (m_len == R2G) begin
          m_mode = 0; m_cur = m_nxt; m_len = 1; np[m_nxt] = 1'b0;
        end else m_len++;
      end
    endcase
    m_pend = np;
  endtask

  task automatic step(input logic [3:0] r, input logic c = 1'b1);
    logic [7:0] es;
    logic [1:0] lamp;
    int nonred;
    bus.req = r;
    clr     = c;
    @(posedge clk);
    model_edge(r, c);
    #1;
    lamp = (m_mode == 0) ? 2'd2 : (m_mode == 1) ? 2'd1 : 2'd0;
    es = 8'(lamp) << (2 * m_cur);
    check("sig",   bus.sig,   es);
    check("grant", bus.grant, m_cur);
    check("phase", bus.phase, m_mode);
    nonred = 0;
    for (int j = 0; j < 4; j++) if (bus.sig[2*j +: 2] != 2'd0) nonred++;
    check("one_lamp", nonred <= 1, 1);
  endtask

  task automatic capture(input logic [3:0] first_req, input int n);
    logic [1:0] prev;
    gq.delete();
    g_cyc = 0; y_cyc = 0; r_cyc = 0;
    prev = bus.phase;
    for (int i = 0; i < n; i++) begin
      step(i == 0 ? first_req : 4'b0000);
      if (bus.phase == 2'd0 && prev == 2'd2) gq.push_back(int'(bus.grant));
      if (bus.phase == 2'd0 && bus.grant != 2'd0) g_cyc++;
      if (bus.phase == 2'd1) y_cyc++;
      if (bus.phase == 2'd2) r_cyc++;
      prev = bus.phase;
    end
  endtask

  task automatic check_order(input string tag, input int exp[4]);
    check({tag, "_count"}, gq.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < gq.size()) check(tag, gq[i], exp[i]);
  endtask

  // Requests approach 2 until it is green, then keeps req[2] high for 'hold' green cycles.
  task automatic green_len(input int hold, output int len);
    int guard;
    len   = 0;
    guard = 0;
    while (bus.sig != 8'h20 && guard < 30) begin
      step(4'b0100);
      guard++;
    end
    check("reach_green2", bus.sig, 8'h20);
    if (bus.sig == 8'h20) begin
      len   = 1;
      guard = 0;
      while (guard < 40) begin
        step(len <= hold ? 4'b0100 : 4'b0000);
        if (bus.sig == 8'h20) len++;
        else break;
        guard++;
      end
    end
  endtask

  initial begin
    logic [7:0] exp_sig[16];
    logic [1:0] exp_grant[16];
    int len;
    int quiet;

    bus.req = 4'b0000;

    // Reset, then rest on home with no demand.
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    check("reset_sig", bus.sig, 8'h02);
    quiet = 0;
    for (int i = 0; i < 50; i++) begin
      step(4'b0000);
      if (bus.sig != 8'h02 || bus.grant != 2'd0 || bus.phase != 2'd0) quiet++;
    end
    check("rest_home", quiet, 0);

    // A single one-cycle pulse on approach 2.
    for (int i = 0; i < 20; i++) step(4'b0000);
    step(4'b0100);
    check("pulse_edge_sig", bus.sig, 8'h02);
    exp_sig   = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h20, 8'h20, 8'h20,
                  8'h20, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h02, 8'h02};
    exp_grant = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2,
                  2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
    for (int i = 0; i < 16; i++) begin
      step(4'b0000);
      check("pulse_seq_sig", bus.sig, exp_sig[i]);
      check("pulse_seq_grant", bus.grant, exp_grant[i]);
    end

    // Green extension while the owner keeps requesting, capped at MAX_G.
    green_len(1000, len);
    check("green_max_len", len, MAX_G);
    for (int i = 0; i < 40; i++) step(4'b0000);
    check("settle1_grant", bus.grant, 2'd0);
    green_len(1, len);
    check("green_min_len", len, MIN_G);
    for (int i = 0; i < 40; i++) step(4'b0000);
    check("settle2_phase", bus.phase, 2'd0);

    // Simultaneous requests on approaches 1, 2 and 3 are served in round-robin order.
    capture(4'b1110, 60);
    check_order("rr_order", '{1, 2, 3, 0});
    check("rr_green_cycles", g_cyc, 3 * MIN_G);
    check("rr_yellow_cycles", y_cyc, 4 * Y2R);
    check("rr_allred_cycles", r_cyc, 4 * R2G);

    // A request from the approach that is already green is consumed without a change of right-of-way.
    step(4'b0001);
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0000);
      if (bus.phase != 2'd0 || bus.grant != 2'd0) quiet++;
    end
    check("self_req_quiet", quiet, 0);

    // A request that arrives during the yellow toward 3 does not change the grant already chosen.
    step(4'b1000);
    step(4'b0000);
    check("yellow_to3", bus.phase, 2'd1);
    capture(4'b0010, 60);
    check_order("late_order", '{3, 0, 1, 0});

    // Reset asserted in the second yellow cycle.
    step(4'b0100);
    step(4'b0000);
    step(4'b0000);
    check("second_yellow", {bus.phase, bus.sig}, {2'd1, 8'h01});
    step(4'b0000, 1'b0);
    check("midreset_sig", bus.sig, 8'h02);
    check("midreset_grant", bus.grant, 2'd0);
    check("midreset_phase", bus.phase, 2'd0);
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0000);
      if (bus.phase != 2'd0) quiet++;
    end
    check("midreset_pend_clear", quiet, 0);

    // Random sensor traffic with occasional resets, checked cycle by cycle against the model.
    for (int i = 0; i < 800; i++) begin
      logic [3:0] r;
      for (int j = 0; j < 4; j++) r[j] = ($urandom_range(0, 7) == 0);
      step(r, ($urandom_range(0, 99) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
